// File: rtl/ibis_tmds_encoder_mc_if.sv
`default_nettype none
// ============================================================================
// Module : ibis_tmds_encoder_mc_if
// Brief  : Pixel-side inputs and symbol-side outputs of the multi-lane TMDS
//          encoder, bundled with driver (master) and encoder (slave) views.
// Rev    : 1.0 - initial release
// ============================================================================
interface ibis_tmds_encoder_mc_if #(
    parameter int CHANNELS = 3,
    parameter int BIAS_W   = 6
);
    logic                       enable;
    logic [1:0]                 mode;
    logic [CHANNELS*8-1:0]      data;
    logic [CHANNELS*2-1:0]      control;
    logic [CHANNELS*4-1:0]      terc4;
    logic [CHANNELS*10-1:0]     out_parallel;
    logic [1:0]                 out_mode;
    logic [CHANNELS*BIAS_W-1:0] debug_bias;

    modport master (
        output enable, mode, data, control, terc4,
        input  out_parallel, out_mode, debug_bias
    );

    modport slave (
        input  enable, mode, data, control, terc4,
        output out_parallel, out_mode, debug_bias
    );
endinterface
`default_nettype wire

// File: rtl/ibis_tmds_encoder_mc.sv
`default_nettype none
// ============================================================================
// Module : ibis_tmds_encoder_mc
// Brief  : Multi-lane two-stage TMDS encoder (video/control, optional guard
//          band and TERC4 data island when IBIS_TMDS_TERC4_EN is defined).
// Rev    : 1.0 - initial release
// ============================================================================
module ibis_tmds_encoder_mc #(
    parameter int CHANNELS = 3,
    parameter int BIAS_W   = 6
) (
    input  wire logic             aclk,
    input  wire logic             areset,
    ibis_tmds_encoder_mc_if.slave bus
);
    localparam logic [1:0] c_MODE_VIDEO = 2'b00;
    localparam logic [1:0] c_MODE_CTRL  = 2'b01;
    localparam logic [9:0] c_CTRL_00    = 10'b1101010100;
`ifdef IBIS_TMDS_TERC4_EN
    localparam logic [1:0] c_MODE_GUARD  = 2'b10;
    localparam logic [1:0] c_MODE_ISLAND = 2'b11;
    localparam logic [9:0] c_GB_EVEN     = 10'b1011001100;
    localparam logic [9:0] c_GB_ODD      = 10'b0100110011;
`endif

    // Transition-minimising stage: q[8] set means XOR chain was used.
    function automatic logic [8:0] f_stage1_q(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Ones minus zeros of the 8-bit word, as a 5-bit two's complement value.
    function automatic logic [4:0] f_balance(input logic [7:0] q);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, q[i]};
        return {n, 1'b0} - 5'd8;
    endfunction

    function automatic logic [9:0] f_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

`ifdef IBIS_TMDS_TERC4_EN
    function automatic logic [9:0] f_terc4(input logic [3:0] t);
        case (t)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction
`endif

    logic [1:0] r_s1_mode;
    logic [1:0] r_out_mode;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_s1_mode  <= c_MODE_CTRL;
            r_out_mode <= c_MODE_CTRL;
        end else if (bus.enable) begin
            r_s1_mode  <= bus.mode;
            r_out_mode <= r_s1_mode;
        end
    end

    assign bus.out_mode = r_out_mode;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
`ifdef IBIS_TMDS_TERC4_EN
        localparam bit c_ODD_LANE = (n % 2) == 1;
        logic [3:0] r_s1_terc4;
`endif
        logic [8:0]               w_s1_q;
        logic [8:0]               r_s1_q;
        logic [4:0]               r_s1_b;
        logic [1:0]               r_s1_ctrl;
        logic [9:0]               r_sym;
        logic signed [BIAS_W-1:0] r_bias;
        logic [9:0]               w_sym;
        logic signed [BIAS_W-1:0] w_bias;
        logic signed [BIAS_W-1:0] w_b_ext;
        logic signed [BIAS_W-1:0] w_q8_x2;
        logic signed [BIAS_W-1:0] w_nq8_x2;

        assign w_s1_q = f_stage1_q(bus.data[8*n +: 8]);

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_s1_q     <= '0;
                r_s1_b     <= '0;
                r_s1_ctrl  <= 2'b00;
`ifdef IBIS_TMDS_TERC4_EN
                r_s1_terc4 <= '0;
`endif
            end else if (bus.enable) begin
                r_s1_q     <= w_s1_q;
                r_s1_b     <= f_balance(w_s1_q[7:0]);
                r_s1_ctrl  <= bus.control[2*n +: 2];
`ifdef IBIS_TMDS_TERC4_EN
                r_s1_terc4 <= bus.terc4[4*n +: 4];
`endif
            end
        end

        // Disparity choice: invert the byte whenever that pulls the running
        // bias back toward zero; q[8] is folded in as the one-bit correction.
        always_comb begin
            w_b_ext  = BIAS_W'($signed(r_s1_b));
            w_q8_x2  = BIAS_W'({r_s1_q[8], 1'b0});
            w_nq8_x2 = BIAS_W'({~r_s1_q[8], 1'b0});
            w_sym    = f_ctrl(r_s1_ctrl);
            w_bias   = '0;
            case (r_s1_mode)
                c_MODE_VIDEO: begin
                    if ((r_bias == '0) || (r_s1_b == '0)) begin
                        w_sym  = {~r_s1_q[8], r_s1_q[8],
                                  r_s1_q[8] ? r_s1_q[7:0] : ~r_s1_q[7:0]};
                        w_bias = r_s1_q[8] ? (r_bias + w_b_ext) : (r_bias - w_b_ext);
                    end else if (r_bias[BIAS_W-1] == r_s1_b[4]) begin
                        w_sym  = {1'b1, r_s1_q[8], ~r_s1_q[7:0]};
                        w_bias = r_bias + w_q8_x2 - w_b_ext;
                    end else begin
                        w_sym  = {1'b0, r_s1_q[8], r_s1_q[7:0]};
                        w_bias = r_bias + w_b_ext - w_nq8_x2;
                    end
                end
`ifdef IBIS_TMDS_TERC4_EN
                c_MODE_GUARD:  w_sym = c_ODD_LANE ? c_GB_ODD : c_GB_EVEN;
                c_MODE_ISLAND: w_sym = f_terc4(r_s1_terc4);
`endif
                default: ;
            endcase
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_sym  <= c_CTRL_00;
                r_bias <= '0;
            end else if (bus.enable) begin
                r_sym  <= w_sym;
                r_bias <= w_bias;
            end
        end

        assign bus.out_parallel[10*n +: 10]       = r_sym;
        assign bus.debug_bias[BIAS_W*n +: BIAS_W] = r_bias;
    end
endmodule
`default_nettype wire
